tlul_host_lsu_adapter: RTL and testbench
========================================

TLUL_HOST_LSU_ADAPTER -- requirements
Module: tlul_host_lsu_adapter

Interface
REQ-001 Parameter SourceId, default 0: value driven on a_source for every request.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_ni  input  1  reset, synchronous, active-low.
REQ-004 lsu_req_i  input  1  core load/store request valid.
REQ-005 lsu_gnt_o  output  1  request accepted this cycle.
REQ-006 lsu_we_i  input  1  1 = store, 0 = load.
REQ-007 lsu_be_i  input  4  byte enables.
REQ-008 lsu_addr_i  input  32  byte address.
REQ-009 lsu_wdata_i  input  32  store data.
REQ-010 lsu_rvalid_o  output  1  one-cycle response pulse.
REQ-011 lsu_rdata_o  output  32  load data, valid with lsu_rvalid_o.
REQ-012 lsu_err_o  output  1  response error, valid with lsu_rvalid_o.
REQ-013 tl_o  output  tlul_pkg::tl_h2d_t  TL-UL host request to the main crossbar LSU host port.
REQ-014 tl_i  input  tlul_pkg::tl_d2h_t  TL-UL response from the crossbar.

Function
REQ-015 FSM states: IDLE, A_PEND, D_WAIT; at most one outstanding transaction.
REQ-016 lsu_gnt_o = lsu_req_i AND state==IDLE (combinational); on grant, all request fields are registered and state -> A_PEND.
REQ-017 a_valid = (state==A_PEND); A-channel fields held stable until a_valid AND a_ready.
REQ-018 a_opcode: load -> Get; store with be==4'hF -> PutFullData; other stores -> PutPartialData.
REQ-019 a_address = {addr[31:2],2'b00}; a_size = 2; a_mask = be for stores, 4'hF for loads; a_data = wdata for stores, 0 for loads; a_source = SourceId; a_param = 0.
REQ-020 A_PEND: a_ready high -> D_WAIT, unless d_valid is also high that cycle, in which case the response is consumed and state -> IDLE.
REQ-021 d_ready = (state==A_PEND OR state==D_WAIT); d_valid in IDLE is ignored.
REQ-022 D_WAIT: on d_valid, state -> IDLE; next cycle lsu_rvalid_o=1 for exactly one cycle.
REQ-023 With that pulse: lsu_rdata_o = d_data for loads, 0 for stores; lsu_err_o = d_error.
REQ-024 Minimum latency: grant cycle 0, a_valid cycle 1, d_valid cycle 1 or later, lsu_rvalid_o at d_valid cycle + 1.
REQ-025 A new grant is allowed in the same cycle lsu_rvalid_o pulses (state already IDLE).
REQ-026 lsu_rdata_o and lsu_err_o hold their last values between pulses.

Reset
REQ-027 When rst_ni==0 at a clock edge: state=IDLE, a_valid=0, d_ready=0, lsu_rvalid_o=0, lsu_err_o=0, lsu_rdata_o=0, captured request registers=0.
REQ-028 Reset during A_PEND or D_WAIT abandons the transaction; no lsu_rvalid_o pulse is produced for it.

Configuration
REQ-029 Macro TLUL_HOST_ALIGN_CHECK_EN defined: a granted request whose be is not in {0001,0010,0100,1000,0011,1100,1111} is not issued on TL-UL; the FSM returns to IDLE and the next cycle pulses lsu_rvalid_o=1, lsu_err_o=1, lsu_rdata_o=0.
REQ-030 Macro undefined: every granted request is issued unchanged, including be==0 and non-contiguous masks.

Structure
REQ-031 The legal byte-mask list and the response-error encoding constants belong in tlul_pkg; the FSM state typedef is local to the module.
REQ-032 One combinational sub-module, tlul_host_mask_chk (input be[3:0], output legal), is instantiated only under TLUL_HOST_ALIGN_CHECK_EN.

Verification
REQ-033 Load addr 0x1000_0004, be=F; device a_ready=1, d_valid 2 cycles later with d_data=0xDEAD_BEEF -> Get, a_address 0x1000_0004, a_mask F; rvalid with rdata 0xDEAD_BEEF, err=0.
REQ-034 Store addr 0x2000_0003, be=0011, wdata 0x1234_5678 -> PutPartialData, a_address 0x2000_0000, a_mask 0011; response rdata=0.
REQ-035 a_ready held low for 5 cycles -> A-channel fields unchanged for all 5 cycles; lsu_gnt_o=0 for a second request.
REQ-036 d_valid with d_error=1 -> lsu_rvalid_o=1, lsu_err_o=1 on the following cycle.
REQ-037 rst_ni low during D_WAIT, then d_valid arrives -> no lsu_rvalid_o pulse; a_valid=0, state IDLE.
REQ-038 With TLUL_HOST_ALIGN_CHECK_EN, store be=0101 -> a_valid never asserted; next cycle lsu_rvalid_o=1, lsu_err_o=1.

Source files
------------

// File: rtl/tlul_pkg.sv
// TL-UL bus types, opcodes, response-error encoding and the legal byte-mask list
// shared by the LSU host adapter and its mask checker.
package tlul_pkg;

  localparam int unsigned TlAw  = 32;
  localparam int unsigned TlDw  = 32;
  localparam int unsigned TlMw  = 4;
  localparam int unsigned TlSzw = 2;
  localparam int unsigned TlAiw = 8;
  localparam int unsigned TlDiw = 1;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  localparam logic RspOk  = 1'b0;
  localparam logic RspErr = 1'b1;

  // Naturally aligned byte, halfword and word masks
  localparam int unsigned NumLegalBe = 7;
  localparam logic [NumLegalBe-1:0][TlMw-1:0] LegalBe = {
    4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111
  };

  typedef struct packed {
    logic             a_valid;
    tl_a_op_e         a_opcode;
    logic [2:0]       a_param;
    logic [TlSzw-1:0] a_size;
    logic [TlAiw-1:0] a_source;
    logic [TlAw-1:0]  a_address;
    logic [TlMw-1:0]  a_mask;
    logic [TlDw-1:0]  a_data;
    logic             d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic             d_valid;
    tl_d_op_e         d_opcode;
    logic [2:0]       d_param;
    logic [TlSzw-1:0] d_size;
    logic [TlAiw-1:0] d_source;
    logic [TlDiw-1:0] d_sink;
    logic [TlDw-1:0]  d_data;
    logic             d_error;
    logic             a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/tlul_host_mask_chk.sv
// Combinational check that a byte-enable pattern is one of the naturally aligned
// masks the adapter may issue on TL-UL.
module tlul_host_mask_chk
  import tlul_pkg::*;
(
  input  logic [TlMw-1:0] be_i,
  output logic            legal_o
);

  always_comb begin
    legal_o = 1'b0;
    for (int unsigned i = 0; i < NumLegalBe; i++) begin
      if (be_i == LegalBe[i]) legal_o = 1'b1;
    end
  end

endmodule

// File: rtl/tlul_host_lsu_adapter.sv
// Bridges the core LSU request/response handshake onto a single-outstanding TL-UL host port.
// Optional feature macro: TLUL_HOST_ALIGN_CHECK_EN rejects unaligned byte masks locally.
module tlul_host_lsu_adapter
  import tlul_pkg::*;
#(
  parameter int unsigned SourceId = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    lsu_req_i,
  output logic                    lsu_gnt_o,
  input  logic                    lsu_we_i,
  input  logic [TlMw-1:0]         lsu_be_i,
  input  logic [TlAw-1:0]         lsu_addr_i,
  input  logic [TlDw-1:0]         lsu_wdata_i,
  output logic                    lsu_rvalid_o,
  output logic [TlDw-1:0]         lsu_rdata_o,
  output logic                    lsu_err_o,
  output tlul_pkg::tl_h2d_t       tl_o,
  input  tlul_pkg::tl_d2h_t       tl_i
);

  typedef enum logic [1:0] {
    Idle  = 2'd0,
    APend = 2'd1,
    DWait = 2'd2
  } state_e;

  state_e            state_q;
  logic              we_q;
  logic [TlMw-1:0]   be_q;
  logic [TlAw-3:0]   addr_q;
  logic [TlDw-1:0]   wdata_q;
  logic              rvalid_q;
  logic [TlDw-1:0]   rdata_q;
  logic              err_q;
  logic              be_legal;

`ifdef TLUL_HOST_ALIGN_CHECK_EN
  tlul_host_mask_chk u_mask_chk (
    .be_i    (lsu_be_i),
    .legal_o (be_legal)
  );
`else
  assign be_legal = 1'b1;
`endif

  assign lsu_gnt_o    = lsu_req_i && (state_q == Idle);
  assign lsu_rvalid_o = rvalid_q;
  assign lsu_rdata_o  = rdata_q;
  assign lsu_err_o    = err_q;

  // Response fields and TL addressing below the word are not needed by the core side
  logic unused_sigs;
  assign unused_sigs = ^{tl_i.d_opcode, tl_i.d_param, tl_i.d_size, tl_i.d_source,
                         tl_i.d_sink, lsu_addr_i[1:0]};

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= Idle;
      we_q     <= 1'b0;
      be_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= RspOk;
    end else begin
      rvalid_q <= 1'b0;
      unique case (state_q)
        Idle: begin
          if (lsu_req_i) begin
            we_q    <= lsu_we_i;
            be_q    <= lsu_be_i;
            addr_q  <= lsu_addr_i[TlAw-1:2];
            wdata_q <= lsu_wdata_i;
            if (be_legal) begin
              state_q <= APend;
            end else begin
              rvalid_q <= 1'b1;
              rdata_q  <= '0;
              err_q    <= RspErr;
            end
          end
        end
        APend: begin
          // A device may answer in the same cycle it accepts the request
          if (tl_i.a_ready && tl_i.d_valid) begin
            state_q  <= Idle;
            rvalid_q <= 1'b1;
            rdata_q  <= we_q ? '0 : tl_i.d_data;
            err_q    <= (tl_i.d_error == RspErr);
          end else if (tl_i.a_ready) begin
            state_q <= DWait;
          end
        end
        DWait: begin
          if (tl_i.d_valid) begin
            state_q  <= Idle;
            rvalid_q <= 1'b1;
            rdata_q  <= we_q ? '0 : tl_i.d_data;
            err_q    <= (tl_i.d_error == RspErr);
          end
        end
        default: state_q <= Idle;
      endcase
    end
  end

  always_comb begin
    tl_o           = '0;
    tl_o.a_valid   = (state_q == APend);
    tl_o.a_opcode  = !we_q ? Get : ((be_q == 4'hF) ? PutFullData : PutPartialData);
    tl_o.a_param   = 3'b000;
    tl_o.a_size    = TlSzw'(2);
    tl_o.a_source  = TlAiw'(SourceId);
    tl_o.a_address = {addr_q, 2'b00};
    tl_o.a_mask    = we_q ? be_q : 4'hF;
    tl_o.a_data    = we_q ? wdata_q : '0;
    tl_o.d_ready   = (state_q == APend) || (state_q == DWait);
  end

endmodule

// File: tb/tb_tlul_host_lsu_adapter.sv
// Randomized self-checking bench for tlul_host_lsu_adapter with a transaction-level
// reference of the expected TL-UL request and LSU response.
module tb_tlul_host_lsu_adapter;
  import tlul_pkg::*;

  localparam int unsigned Src = 5;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        lsu_req_i, lsu_gnt_o, lsu_we_i;
  logic [3:0]  lsu_be_i;
  logic [31:0] lsu_addr_i, lsu_wdata_i;
  logic        lsu_rvalid_o, lsu_err_o;
  logic [31:0] lsu_rdata_o;
  tl_h2d_t     tl_o;
  tl_d2h_t     tl_i;

  tlul_host_lsu_adapter #(.SourceId(Src)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .lsu_req_i    (lsu_req_i),
    .lsu_gnt_o    (lsu_gnt_o),
    .lsu_we_i     (lsu_we_i),
    .lsu_be_i     (lsu_be_i),
    .lsu_addr_i   (lsu_addr_i),
    .lsu_wdata_i  (lsu_wdata_i),
    .lsu_rvalid_o (lsu_rvalid_o),
    .lsu_rdata_o  (lsu_rdata_o),
    .lsu_err_o    (lsu_err_o),
    .tl_o         (tl_o),
    .tl_i         (tl_i)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  bit          have_rsp = 1'b0;
  logic [31:0] exp_rdata, last_rdata;
  logic        exp_err, last_err;
  logic [2:0]  e_op;
  logic [31:0] e_addr, e_data;
  logic [3:0]  e_mask;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_idle();
    lsu_req_i    = 1'b0;
    lsu_we_i     = 1'($urandom);
    lsu_be_i     = 4'($urandom);
    lsu_addr_i   = $urandom;
    lsu_wdata_i  = $urandom;
    tl_i         = '0;
    tl_i.d_data  = $urandom;
  endtask

  // A competing request while busy must never be granted
  task automatic drive_noise_req();
    drive_idle();
    lsu_req_i = 1'($urandom);
  endtask

  task automatic check_a();
    check_val("a_valid", 32'(tl_o.a_valid), 32'd1);
    check_val("a_opcode", 32'(tl_o.a_opcode), 32'(e_op));
    check_val("a_address", tl_o.a_address, e_addr);
    check_val("a_size", 32'(tl_o.a_size), 32'd2);
    check_val("a_mask", 32'(tl_o.a_mask), 32'(e_mask));
    check_val("a_data", tl_o.a_data, e_data);
    check_val("a_source", 32'(tl_o.a_source), 32'(Src));
    check_val("a_param", 32'(tl_o.a_param), 32'd0);
  endtask

  task automatic check_rsp();
    check_val("rvalid_pulse", 32'(lsu_rvalid_o), 32'd1);
    check_val("rdata", lsu_rdata_o, exp_rdata);
    check_val("err", 32'(lsu_err_o), 32'(exp_err));
    check_val("a_valid_rsp", 32'(tl_o.a_valid), 32'd0);
    last_rdata = exp_rdata;
    last_err   = exp_err;
    have_rsp   = 1'b0;
  endtask

  task automatic check_quiet();
    check_val("rvalid_quiet", 32'(lsu_rvalid_o), 32'd0);
    check_val("rdata_hold", lsu_rdata_o, last_rdata);
    check_val("err_hold", 32'(lsu_err_o), 32'(last_err));
  endtask

  task automatic flush_rsp();
    if (have_rsp) begin
      @(negedge clk);
      drive_idle();
      #1;
      check_rsp();
      @(posedge clk);
    end
  endtask

  task automatic do_txn(input logic we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wdata, input int a_wait, input bit d_same,
                        input int d_lat, input logic [31:0] dd, input logic de, input bit b2b);
    bit legal;
    legal = 1'b1;
`ifdef TLUL_HOST_ALIGN_CHECK_EN
    legal = be inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
`endif
    if (!b2b) flush_rsp();
    @(negedge clk);
    drive_idle();
    lsu_req_i   = 1'b1;
    lsu_we_i    = we;
    lsu_be_i    = be;
    lsu_addr_i  = addr;
    lsu_wdata_i = wdata;
    #1;
    if (have_rsp) check_rsp(); else check_quiet();
    check_val("gnt", 32'(lsu_gnt_o), 32'd1);
    @(posedge clk);
    if (!legal) begin
      have_rsp  = 1'b1;
      exp_rdata = 32'h0;
      exp_err   = 1'b1;
      return;
    end
    e_op   = !we ? 3'd4 : ((be == 4'hF) ? 3'd0 : 3'd1);
    e_addr = addr & 32'hFFFF_FFFC;
    e_mask = we ? be : 4'hF;
    e_data = we ? wdata : 32'h0;
    for (int i = 0; i < a_wait; i++) begin
      @(negedge clk);
      drive_noise_req();
      #1;
      check_a();
      check_val("gnt_busy", 32'(lsu_gnt_o), 32'd0);
      check_val("d_ready_apend", 32'(tl_o.d_ready), 32'd1);
      check_quiet();
      @(posedge clk);
    end
    @(negedge clk);
    drive_noise_req();
    tl_i.a_ready = 1'b1;
    if (d_same) begin
      tl_i.d_valid = 1'b1;
      tl_i.d_data  = dd;
      tl_i.d_error = de;
    end
    #1;
    check_a();
    check_val("gnt_busy", 32'(lsu_gnt_o), 32'd0);
    @(posedge clk);
    if (!d_same) begin
      for (int i = 0; i < d_lat; i++) begin
        @(negedge clk);
        drive_noise_req();
        #1;
        check_val("a_valid_dwait", 32'(tl_o.a_valid), 32'd0);
        check_val("d_ready_dwait", 32'(tl_o.d_ready), 32'd1);
        check_val("gnt_busy", 32'(lsu_gnt_o), 32'd0);
        check_quiet();
        @(posedge clk);
      end
      @(negedge clk);
      drive_idle();
      tl_i.d_valid = 1'b1;
      tl_i.d_data  = dd;
      tl_i.d_error = de;
      #1;
      check_val("d_ready_dvalid", 32'(tl_o.d_ready), 32'd1);
      @(posedge clk);
    end
    have_rsp  = 1'b1;
    exp_rdata = we ? 32'h0 : dd;
    exp_err   = de;
  endtask

  // Reset while waiting for D abandons the load; a late d_valid must be ignored
  task automatic reset_in_dwait();
    flush_rsp();
    @(negedge clk);
    drive_idle();
    lsu_req_i  = 1'b1;
    lsu_we_i   = 1'b0;
    lsu_be_i   = 4'hF;
    lsu_addr_i = $urandom;
    #1;
    check_val("gnt_rst", 32'(lsu_gnt_o), 32'd1);
    @(posedge clk);
    @(negedge clk);
    drive_idle();
    tl_i.a_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    drive_idle();
    rst_ni = 1'b0;
    #1;
    check_val("d_ready_pre_rst", 32'(tl_o.d_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    drive_idle();
    tl_i.d_valid = 1'b1;
    tl_i.d_data  = 32'hBAD0_BAD0;
    #1;
    check_val("a_valid_post_rst", 32'(tl_o.a_valid), 32'd0);
    check_val("d_ready_post_rst", 32'(tl_o.d_ready), 32'd0);
    check_val("rvalid_post_rst", 32'(lsu_rvalid_o), 32'd0);
    check_val("rdata_post_rst", lsu_rdata_o, 32'd0);
    check_val("err_post_rst", 32'(lsu_err_o), 32'd0);
    @(posedge clk);
    last_rdata = 32'h0;
    last_err   = 1'b0;
    @(negedge clk);
    drive_idle();
    #1;
    check_val("rvalid_stray_d", 32'(lsu_rvalid_o), 32'd0);
    @(posedge clk);
  endtask

  initial begin
    rst_ni = 1'b0;
    drive_idle();
    last_rdata = 32'h0;
    last_err   = 1'b0;
    exp_rdata  = 32'h0;
    exp_err    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_a_valid", 32'(tl_o.a_valid), 32'd0);
    check_val("rst_d_ready", 32'(tl_o.d_ready), 32'd0);
    check_val("rst_rvalid", 32'(lsu_rvalid_o), 32'd0);
    check_val("rst_rdata", lsu_rdata_o, 32'd0);
    check_val("rst_err", 32'(lsu_err_o), 32'd0);
    rst_ni = 1'b1;
    @(posedge clk);

    do_txn(1'b0, 4'hF, 32'h1000_0004, 32'h0, 0, 1'b0, 1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    do_txn(1'b1, 4'b0011, 32'h2000_0003, 32'h1234_5678, 0, 1'b0, 0, 32'h5555_AAAA, 1'b0, 1'b0);
    do_txn(1'b1, 4'hF, 32'h3000_0008, 32'hCAFE_F00D, 5, 1'b0, 2, 32'h0, 1'b0, 1'b1);
    do_txn(1'b0, 4'hF, 32'h4000_0010, 32'h0, 0, 1'b1, 0, 32'h0BAD_CAFE, 1'b1, 1'b1);
    do_txn(1'b1, 4'b0101, 32'h5000_0000, 32'hFFFF_0000, 1, 1'b0, 0, 32'h0, 1'b0, 1'b0);
    do_txn(1'b1, 4'b0000, 32'h6000_0001, 32'h1111_2222, 0, 1'b1, 0, 32'h0, 1'b0, 1'b1);
    reset_in_dwait();

    for (int n = 0; n < 200; n++) begin
      do_txn(1'($urandom), 4'($urandom), $urandom, $urandom, int'($urandom_range(0, 3)),
             ($urandom_range(0, 2) == 0), int'($urandom_range(0, 3)), $urandom,
             ($urandom_range(0, 4) == 0), 1'($urandom));
      if (n % 67 == 66) reset_in_dwait();
    end
    flush_rsp();
    @(negedge clk);
    drive_idle();
    #1;
    check_quiet();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
